// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: states, opcodes,
// datapath select encodings and the packed control-output bundle.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        ADDI_EX   = 4'd9,
        ADDI_WB   = 4'd10,
        JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(16'd0);

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control decode; only pc_write and ir_write look at
// mem_ready. JUMP decode is present only with MULTICYCLE_JUMP_EN.
module mc_output_decode
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Per-state datapath enables and selects; anything unlisted stays low.
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready stalls and a retired-instruction
// counter. Define MULTICYCLE_JUMP_EN to support the j instruction.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OPC_W-1:0] Op,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_r;
    state_t           state_s;
    logic             illegal_s;
    logic             retire_s;
    logic [CNT_W-1:0] retired_r;
    ctrl_t            ctrl_s;
    logic             unused_zero_s;

    // The branch decision is made in the datapath, which gates PC with Zero.
    assign unused_zero_s = Zero;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection and illegal-opcode detection.
    always_comb begin
        state_s   = state_r;
        illegal_s = 1'b0;
        case (state_r)
            FETCH: begin
                if (mem_ready) state_s = DECODE;
                else           state_s = FETCH;
            end
            DECODE: begin
                case (Op)
                    OPC_W'(OP_LW), OPC_W'(OP_SW): state_s = MEM_ADDR;
                    OPC_W'(OP_RTYPE):             state_s = EXECUTE;
                    OPC_W'(OP_BEQ):               state_s = BRANCH;
                    OPC_W'(OP_ADDI):              state_s = ADDI_EX;
`ifdef MULTICYCLE_JUMP_EN
                    OPC_W'(OP_J):                 state_s = JUMP;
`endif
                    default: begin
                        state_s   = FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                if (Op == OPC_W'(OP_SW)) state_s = MEM_WRITE;
                else                     state_s = MEM_READ;
            end
            MEM_READ: begin
                if (mem_ready) state_s = MEM_WB;
                else           state_s = MEM_READ;
            end
            MEM_WRITE: begin
                if (mem_ready) state_s = FETCH;
                else           state_s = MEM_WRITE;
            end
            EXECUTE:  state_s = R_WB;
            ADDI_EX:  state_s = ADDI_WB;
            MEM_WB, R_WB, BRANCH, ADDI_WB: state_s = FETCH;
`ifdef MULTICYCLE_JUMP_EN
            JUMP:     state_s = FETCH;
`endif
            default:  state_s = FETCH;
        endcase
    end

    // A FETCH stall loop is not a new instruction, and an illegal exit never retires.
    assign retire_s = (state_s == FETCH) && (state_r != FETCH) && !illegal_s;

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    mc_output_decode u_output_decode (
        .state     (state_r),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    assign PCWrite     = ctrl_s.pc_write;
    assign PCWriteCond = ctrl_s.pc_write_cond;
    assign IorD        = ctrl_s.i_or_d;
    assign MemRead     = ctrl_s.mem_read;
    assign MemWrite    = ctrl_s.mem_write;
    assign MemtoReg    = ctrl_s.mem_to_reg;
    assign IRWrite     = ctrl_s.ir_write;
    assign RegWrite    = ctrl_s.reg_write;
    assign RegDst      = ctrl_s.reg_dst;
    assign ALUSrcA     = ctrl_s.alu_src_a;
    assign ALUSrcB     = ctrl_s.alu_src_b;
    assign ALUOp       = ctrl_s.alu_op;
    assign PCSource    = ctrl_s.pc_source;
    assign illegal     = illegal_s;
    assign retired     = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven cycle-by-cycle check of multicycle_control outputs, plus an
// asynchronous reset during a store stall.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        illegal;
    logic [31:0] retired;
    logic [15:0] act_ctrl;

    int errors = 0;
    int checks = 0;

    // Expected control words: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,
    // MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    localparam logic [15:0] C_F1  = 16'b1001001000_01_00_00;
    localparam logic [15:0] C_F0  = 16'b0001000000_01_00_00;
    localparam logic [15:0] C_DEC = 16'b0000000000_11_00_00;
    localparam logic [15:0] C_MAD = 16'b0000000001_10_00_00;
    localparam logic [15:0] C_MRD = 16'b0011000000_00_00_00;
    localparam logic [15:0] C_MWB = 16'b0000010100_00_00_00;
    localparam logic [15:0] C_MWR = 16'b0010100000_00_00_00;
    localparam logic [15:0] C_EXE = 16'b0000000001_00_10_00;
    localparam logic [15:0] C_RWB = 16'b0000000110_00_00_00;
    localparam logic [15:0] C_BR  = 16'b0100000001_00_01_01;
    localparam logic [15:0] C_AEX = 16'b0000000001_10_00_00;
    localparam logic [15:0] C_AWB = 16'b0000000100_00_00_00;
    localparam logic [15:0] C_JMP = 16'b1000000000_00_00_10;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [15:0] ctrl;
        logic        ill;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    multicycle_control dut (
        .clock       (clock),
        .reset       (reset),
        .Op          (op),
        .Zero        (zero),
        .mem_ready   (mem_ready),
        .PCWrite     (pc_write),
        .PCWriteCond (pc_write_cond),
        .IorD        (i_or_d),
        .MemRead     (mem_read),
        .MemWrite    (mem_write),
        .MemtoReg    (mem_to_reg),
        .IRWrite     (ir_write),
        .RegWrite    (reg_write),
        .RegDst      (reg_dst),
        .ALUSrcA     (alu_src_a),
        .ALUSrcB     (alu_src_b),
        .ALUOp       (alu_op),
        .PCSource    (pc_source),
        .illegal     (illegal),
        .retired     (retired)
    );

    assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                       mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a,
                       alu_src_b, alu_op, pc_source};

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic m, input logic [15:0] c,
                       input logic il, input int r);
        vec_t v;
        v.op = o; v.mr = m; v.ctrl = c; v.ill = il; v.ret = 32'(r);
        vecs.push_back(v);
    endtask

    initial begin
        int jx;
`ifdef MULTICYCLE_JUMP_EN
        jx = 1;
`else
        jx = 0;
`endif
        // R-type, 4 cycles
        add(6'h00, 1'b1, C_F1,  1'b0, 0); add(6'h00, 1'b1, C_DEC, 1'b0, 0);
        add(6'h00, 1'b1, C_EXE, 1'b0, 0); add(6'h00, 1'b1, C_RWB, 1'b0, 0);
        // addi, 4 cycles
        add(6'h08, 1'b1, C_F1,  1'b0, 1); add(6'h08, 1'b1, C_DEC, 1'b0, 1);
        add(6'h08, 1'b1, C_AEX, 1'b0, 1); add(6'h08, 1'b1, C_AWB, 1'b0, 1);
        // lw with two stall cycles in MEM_READ, 7 cycles
        add(6'h23, 1'b1, C_F1,  1'b0, 2); add(6'h23, 1'b1, C_DEC, 1'b0, 2);
        add(6'h23, 1'b1, C_MAD, 1'b0, 2); add(6'h23, 1'b0, C_MRD, 1'b0, 2);
        add(6'h23, 1'b0, C_MRD, 1'b0, 2); add(6'h23, 1'b1, C_MRD, 1'b0, 2);
        add(6'h23, 1'b1, C_MWB, 1'b0, 2);
        // sw, 4 cycles
        add(6'h2B, 1'b1, C_F1,  1'b0, 3); add(6'h2B, 1'b1, C_DEC, 1'b0, 3);
        add(6'h2B, 1'b1, C_MAD, 1'b0, 3); add(6'h2B, 1'b1, C_MWR, 1'b0, 3);
        // beq, 3 cycles
        add(6'h04, 1'b1, C_F1,  1'b0, 4); add(6'h04, 1'b1, C_DEC, 1'b0, 4);
        add(6'h04, 1'b1, C_BR,  1'b0, 4);
        // illegal opcode: pulse in DECODE, no retire
        add(6'h3F, 1'b1, C_F1,  1'b0, 5); add(6'h3F, 1'b1, C_DEC, 1'b1, 5);
        // j: legal only with the jump macro
        add(6'h02, 1'b1, C_F1,  1'b0, 5);
`ifdef MULTICYCLE_JUMP_EN
        add(6'h02, 1'b1, C_DEC, 1'b0, 5); add(6'h02, 1'b1, C_JMP, 1'b0, 5);
`else
        add(6'h02, 1'b1, C_DEC, 1'b1, 5);
`endif
        // FETCH stall then R-type
        add(6'h00, 1'b0, C_F0,  1'b0, 5 + jx); add(6'h00, 1'b1, C_F1,  1'b0, 5 + jx);
        add(6'h00, 1'b1, C_DEC, 1'b0, 5 + jx); add(6'h00, 1'b1, C_EXE, 1'b0, 5 + jx);
        add(6'h00, 1'b1, C_RWB, 1'b0, 5 + jx); add(6'h00, 1'b1, C_F1,  1'b0, 6 + jx);

        // Reset held with mem_ready high
        repeat (2) @(negedge clock);
        #1;
        chk("reset_ctrl", 32'(act_ctrl), 32'(C_F1));
        chk("reset_retired", retired, 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            op        = vecs[i].op;
            mem_ready = vecs[i].mr;
            zero      = i[0];
            #1;
            chk($sformatf("vec%0d_ctrl", i), 32'(act_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_retired", i), retired, vecs[i].ret);
            @(negedge clock);
        end

        // Finish the R-type left in DECODE, then store with a write stall
        op = 6'h00; mem_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("pre_sw_ctrl", 32'(act_ctrl), 32'(C_F1));
        chk("pre_sw_retired", retired, 32'(7 + jx));
        op = 6'h2B;
        repeat (3) @(negedge clock);
        mem_ready = 1'b0;
        #1;
        chk("sw_stall_ctrl", 32'(act_ctrl), 32'(C_MWR));
        @(negedge clock);
        #1;
        chk("sw_stall_hold", 32'(act_ctrl), 32'(C_MWR));
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_memwrite", 32'(mem_write), 32'd0);
        chk("async_rst_ctrl", 32'(act_ctrl), 32'(C_F0));
        chk("async_rst_retired", retired, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'b1;
        op = 6'h00;
        #1;
        chk("post_rst_ctrl", 32'(act_ctrl), 32'(C_F1));
        repeat (4) @(negedge clock);
        #1;
        chk("post_rst_retired", retired, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the shared MIPS datapath over several cycles per instruction, replacing the single-cycle `Control` decode. It issues every datapath select and enable per cycle: PC, IR, ALU operand muxes, register file, and a single shared instruction/data memory. It also stalls on a memory-ready handshake. The block sits beside the datapath, takes the opcode and ALU `Zero` flag, and drives the datapath mux selects and enables directly.

## Interface
- `OPC_W`, default 6: opcode width.
- `CNT_W`, default 32: retired-instruction counter width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Op` in `OPC_W`: `instr[31:26]` from the instruction register.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1: datapath enables and selects.
- `ALUSrcB` out 2: ALU B operand select. 00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `ALUOp` out 2: passed to `ALUControl`. 00 = add, 01 = sub, 10 = funct.
- `PCSource` out 2: PC source select. 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `retired` out `CNT_W`: count of completed instructions.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP.
- All outputs not listed for a state are 0. `PCWrite` and `IRWrite` are the only outputs that depend on inputs (Mealy); all others depend on state only.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00. `IRWrite`=`PCWrite`=`mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `ALUSrcB`=11, `ALUOp`=00. Next state by `Op`:
  - 0x23 or 0x2B → MEM_ADDR.
  - 0x00 → EXECUTE.
  - 0x04 → BRANCH.
  - 0x08 → ADDI_EX.
  - 0x02 → JUMP (only when `JUMP_EN` is defined).
  - Any other value → FETCH with `illegal`=1 in this cycle.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `MemRead`=1, `IorD`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Go to FETCH.
- MEM_WRITE: `MemWrite`=1, `IorD`=1. Hold until `mem_ready`, then go to FETCH.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Go to R_WB.
- R_WB: `RegWrite`=1, `RegDst`=1. Go to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. Go to FETCH. The datapath gates the PC update with `Zero`.
- ADDI_EX: `ALUSrcA`=1, `ALUSrcB`=10. Go to ADDI_WB.
- ADDI_WB: `RegWrite`=1, `RegDst`=0. Go to FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Go to FETCH.
- `retired` increments by 1 on every transition into FETCH, except:
  - the illegal exit from DECODE;
  - the exit from reset.
- `retired` wraps modulo 2^`CNT_W`.

## Timing
- Reset (`reset`=0) is asynchronous. It forces state to FETCH, `retired` to 0 and `illegal` to 0. Outputs then take the FETCH decode, with `IRWrite`=`PCWrite`=`mem_ready`.
- Reset asserted mid-instruction aborts the instruction with no retire count. A write already issued to memory is not recalled.
- Cycles per instruction with `mem_ready` tied to 1:
  - R-type: 4.
  - addi: 4.
  - lw: 5.
  - sw: 4.
  - beq: 3.
  - j: 3.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Enables stay steady throughout the stall.
- `illegal` is high for exactly one cycle: the DECODE cycle with the unknown opcode.

## Configuration
- `MULTICYCLE_JUMP_EN` defined: the JUMP state exists, and opcode 0x02 takes 3 cycles and retires.
- `MULTICYCLE_JUMP_EN` undefined: opcode 0x02 is illegal, `PCSource` never takes 10, and the JUMP state is not built.

## Structure
- Shared package `mips_pkg` holds:
  - the state enumeration;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`;
  - `ALUSrcB`, `ALUOp` and `PCSource` encodings.
- One combinational sub-module, `mc_output_decode`, maps state and `mem_ready` to the output vector. The state register, next-state logic and counter stay in `multicycle_control`.

## Test plan
- Reset: hold `reset`=0 with `mem_ready`=1 → state FETCH, `MemRead`=1, `IRWrite`=`PCWrite`=1, `retired`=0.
- R-type: `Op`=0x00 with `mem_ready`=1 → states FETCH, DECODE, EXECUTE, R_WB (4 cycles); R_WB shows `RegWrite`=1 and `RegDst`=1; `retired`=1.
- Load with stall: `Op`=0x23, `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total; `RegWrite` and `MemtoReg` high only in MEM_WB.
- Branch: `Op`=0x04 → BRANCH cycle shows `PCWriteCond`=1, `PCSource`=01, `ALUOp`=01; the instruction takes 3 cycles.
- Illegal opcode: `Op`=0x3F → `illegal` pulses once in DECODE, next state FETCH, `retired` unchanged.
- Reset during MEM_WRITE stall → state FETCH and `MemWrite`=0 immediately (asynchronously), `retired` reset to 0. With the macro undefined, `Op`=0x02 raises `illegal`.
